// File: rtl/progmem_arbiter_pkg.sv
// Shared types and build-time constants for the program-memory arbiter.
// Widths normally come from defines.vh; the fallbacks keep this slice self-contained.
`ifndef INST_W
`define INST_W 32
`endif
`ifndef INST_ADDR_W
`define INST_ADDR_W 16
`endif
`ifndef ARB_MAX_CORES
`define ARB_MAX_CORES 8
`endif

package progmem_arbiter_pkg;

  localparam int ARB_MAX_CORES = `ARB_MAX_CORES;

  // Burst ownership: idle means no core currently holds the memory port.
  typedef enum logic {
    ARB_IDLE,
    ARB_OWNED
  } arb_state_e;

  // Where this cycle's grant came from.
  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_BURST,
    SEL_ARB
  } grant_src_e;

endpackage

// File: rtl/progmem_arbiter_rr_pick.sv
// Rotating-priority encoder: first set bit of req at or after start, wrapping.
module rr_pick
  import progmem_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [2*N-1:0]   req_dbl;
  logic [N-1:0]     req_rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  // Doubling the vector turns the wrap-around scan into a plain shift.
  assign req_dbl = {req, req};
  assign req_rot = N'(req_dbl >> start);

  always_comb begin
    found = |req_rot;
    off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) off = IDX_W'(k);
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= (IDX_W + 1)'(N)) idx = IDX_W'(sum - (IDX_W + 1)'(N));
    else                        idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/progmem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read program memory among N_CORES
// fetch units, with bounded burst ownership and a one-cycle return path.
module progmem_arbiter
  import progmem_arbiter_pkg::*;
#(
  parameter int N_CORES     = 4,
  parameter int MAX_BURST   = 2,
  parameter int INST_W      = `INST_W,
  parameter int INST_ADDR_W = `INST_ADDR_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [N_CORES-1:0]             core_req,
  input  logic [N_CORES*INST_ADDR_W-1:0] core_addr,
  output logic [N_CORES-1:0]             core_stall,
  output logic [N_CORES-1:0]             core_valid,
  output logic [INST_W-1:0]              core_data,
  output logic                           mem_en,
  output logic [INST_ADDR_W-1:0]         mem_addr,
  input  logic [INST_W-1:0]              mem_data
);

  localparam int IDX_W = $clog2(N_CORES);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  if (N_CORES < 2 || N_CORES > ARB_MAX_CORES || MAX_BURST < 1) begin : g_bad_param
    $error("progmem_arbiter: N_CORES must be 2..%0d and MAX_BURST >= 1", ARB_MAX_CORES);
  end

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  grant_src_e       src;

  logic [IDX_W-1:0] scan_start;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_req;

  logic             vld_p0;
  logic [IDX_W-1:0] idx_p0;
  logic [N_CORES-1:0] grant_oh;
  logic             vld_p1;
  logic [IDX_W-1:0] idx_p1;

  assign scan_start = (ptr_q == IDX_W'(N_CORES - 1)) ? '0 : ptr_q + 1'b1;
  assign owner_req  = core_req[owner_q];

  rr_pick #(
    .N     (N_CORES),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (core_req),
    .start (scan_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // ---- stage p0: grant selection, drives the memory port combinationally ----
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    src         = SEL_NONE;
    if (en && !rst) begin
      if (state_q == ARB_OWNED && owner_req && burst_cnt_q < BURST_LAST) begin
        src         = SEL_BURST;
        burst_cnt_d = burst_cnt_q + 1'b1;
      end else if (pick_found) begin
        // Winning again with nobody else waiting still opens a fresh burst.
        src         = SEL_ARB;
        ptr_d       = pick_idx;
        owner_d     = pick_idx;
        state_d     = ARB_OWNED;
        burst_cnt_d = '0;
      end else begin
        state_d = ARB_IDLE;
      end
    end
    vld_p0 = (src != SEL_NONE);
    idx_p0 = (src == SEL_ARB) ? pick_idx : owner_q;
  end

  always_comb begin
    grant_oh = '0;
    mem_addr = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (vld_p0 && idx_p0 == IDX_W'(i)) begin
        grant_oh[i] = 1'b1;
        mem_addr    = core_addr[i*INST_ADDR_W +: INST_ADDR_W];
      end
    end
  end

  assign mem_en     = vld_p0;
  assign core_stall = core_req & ~grant_oh;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= IDX_W'(N_CORES - 1);
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // ---- stage p1: response routing, memory data arrives this cycle ----
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld_p0;
    idx_p1 <= idx_p0;
  end

  always_comb begin
    core_valid = '0;
    for (int i = 0; i < N_CORES; i++) begin
      core_valid[i] = vld_p1 && (idx_p1 == IDX_W'(i));
    end
  end

  assign core_data = mem_data;

endmodule

// File: doc/progmem_arbiter.md
# progmem_arbiter

Shares one synchronous-read program-memory port among `N_CORES` cores, each of which drives a `progmem_addr` and consumes `progmem_data` as a CORE fetch stage does. The block sits between the per-core fetch interfaces and the single instruction memory. Arbitration is round-robin with bounded burst ownership. Each losing requester gets a stall so its STAGE_FE can hold. Read data is routed back to the granted core one cycle after grant.

## Interface
- `N_CORES`, default 4: number of requesting cores, 2..8.
- `MAX_BURST`, default 2: maximum consecutive grants held by one core while others wait; 1 gives pure round-robin.
- `INST_W`, default `` `INST_W ``: instruction width.
- `INST_ADDR_W`, default `` `INST_ADDR_W ``: program address width.
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `en`  in  1  global enable; low freezes arbitration state.
- `core_req`  in  N_CORES  per-core fetch request.
- `core_addr`  in  N_CORES*INST_ADDR_W  flattened fetch addresses; core i occupies bits [i*INST_ADDR_W +: INST_ADDR_W].
- `core_stall`  out  N_CORES  request present but not granted this cycle.
- `core_valid`  out  N_CORES  one-hot; `core_data` is valid for that core.
- `core_data`  out  INST_W  returned instruction, broadcast to all cores.
- `mem_en`  out  1  memory read strobe.
- `mem_addr`  out  INST_ADDR_W  memory read address.
- `mem_data`  in  INST_W  memory read data, one cycle after `mem_en`.

## Operation
State:
- `ptr`: last arbitration winner. Reset value N_CORES-1, so core 0 wins first.
- `owner_vld` / `owner`: current burst holder.
- `burst_cnt`: grants already given to `owner` in the current burst, minus one.
- `resp_vld` / `resp_idx`: return pipeline register.

Grant selection, combinational, evaluated only when `en & ~rst`:
- **Burst continue:** if `owner_vld & core_req[owner] & burst_cnt < MAX_BURST-1`, grant `owner` and increment `burst_cnt`.
- **Otherwise, arbitration:** scan requesters starting at `ptr+1` and wrapping modulo N_CORES. The first requester wins.
  - On a win, set `ptr` and `owner` to the winner, set `owner_vld`, and set `burst_cnt` to 0.
  - If the winner equals the old owner (no other requester was waiting), a new burst begins.
- **No requester:** clear `owner_vld`. `ptr` is unchanged.
- **Owner deasserts `core_req`:** the burst ends immediately and arbitration proceeds that same cycle.

Outputs while a grant is made:
- `mem_en`=1.
- `mem_addr` = address of the granted core.
- `core_stall[i]` = `core_req[i] & ~grant[i]`.

Enable and reset:
- When `en`=0 or `rst`=1: no grant, `mem_en`=0, `core_stall` = `core_req`, and all state is held (rst: state loads its reset values instead).

Return path:
- `resp_vld` is registered as `mem_en`, and `resp_idx` is registered as the grant index.
- `core_valid` = `resp_vld` ? onehot(`resp_idx`) : 0.
- `core_data` = `mem_data`, passed through with no register.

Reset values after a `rst` cycle:
- `ptr`=N_CORES-1, `owner_vld`=0, `burst_cnt`=0, `resp_vld`=0.
- `core_valid`=0, `mem_en`=0.
- `core_stall` = `core_req` during the reset cycle.

## Timing
- Grant latency is 0: a request in cycle t can be granted in t, with `mem_en`/`mem_addr` driven in t.
- Data latency is 1: `core_valid`/`core_data` for a grant in t appear in t+1.
- Throughput: one fetch per cycle in aggregate.
- Worst-case wait for any requester: (N_CORES-1)*MAX_BURST cycles.
- `en` low in cycle t:
  - A response from a grant in t-1 is still delivered in t, because `resp_vld` updates only from `mem_en`.
  - No new response appears in t+1.
- `rst` in cycle t clears `resp_vld`, so a response owed in t+1 is dropped. The core must refetch.
- Simultaneous owner drop and new requests: resolved in the same cycle by arbitration.
- Pointer wrap: after N_CORES-1, the scan restarts at 0.
- A single requester is granted every cycle and is never stalled.

## Structure
- `` `INST_W `` and `` `INST_ADDR_W `` come from `defines.vh`.
- Add `` `ARB_MAX_CORES `` (8) to `defines.vh` for the parameter bound check.
- Sub-module `rr_pick`: combinational rotating-priority encoder. Inputs are `req[N]` and `start` index; outputs are `found` and `idx`. It is instantiated once in `progmem_arbiter`.
- The remaining logic (burst FSM, return register, muxes) stays in `progmem_arbiter`.

## Test plan
All scenarios use N_CORES=4 and MAX_BURST=2. The model memory returns `mem_data` = {addr} one cycle after `mem_en`.

1. **Reset then request:** `rst` high 1 cycle, then `core_req`=4'b1111 with addresses 0x10/0x20/0x30/0x40 → first grant goes to core 0 with `mem_addr`=0x10; next cycle `core_valid`=4'b0001 and `core_data`=0x10.
2. **All four requesting for 10 cycles** → grant sequence 0,0,1,1,2,2,3,3,0,0; stalled cores see `core_stall` high on every cycle they are not granted.
3. **Only core 2 requests for 5 cycles** → granted every cycle, `core_stall`=0 throughout, `core_valid`=4'b0100 for 5 consecutive cycles starting one cycle after the first grant.
4. **Owner drops mid-burst:** core 1 wins with core 3 waiting, then core 1 drops `core_req` → core 3 is granted the next cycle and `burst_cnt` restarts at 0.
5. **`en` low for 3 cycles** mid-sequence 1,1,2 → `mem_en`=0 for those 3 cycles and all requesters stalled; after `en` returns, the sequence resumes with the remaining grant of the interrupted burst.
6. **`rst` during core 2's burst with a response pending** → `core_valid`=0 the following cycle; with all cores requesting, the next grant goes to core 0.
